// File: rtl/aes_word_stream_port.sv
// aes_word_stream_port
// Responder for the AES controller's per-word streamer handshake. Single-word
// read (source) and write (sink) requests are latched independently and then
// executed one at a time on a shared 32-bit TCDM master port. Read words are
// handed to the engine on a valid/ready stream, and write words are taken from
// the engine on a valid/ready stream.

module aes_word_stream_port #(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  clear,

    input  logic                  src_req_start_i,
    input  logic [ADDR_WIDTH-1:0] src_base_addr_i,
    output logic                  src_ready_start_o,
    output logic                  src_done_o,
    output logic [DATA_WIDTH-1:0] src_data_o,
    output logic                  src_valid_o,
    input  logic                  src_ready_i,

    input  logic                  snk_req_start_i,
    input  logic [ADDR_WIDTH-1:0] snk_base_addr_i,
    output logic                  snk_ready_start_o,
    output logic                  snk_done_o,
    input  logic [DATA_WIDTH-1:0] snk_data_i,
    input  logic                  snk_valid_i,
    output logic                  snk_ready_o,

    output logic                  tcdm_req_o,
    input  logic                  tcdm_gnt_i,
    output logic [ADDR_WIDTH-1:0] tcdm_add_o,
    output logic                  tcdm_wen_o,
    output logic [3:0]            tcdm_be_o,
    output logic [DATA_WIDTH-1:0] tcdm_data_o,
    input  logic [DATA_WIDTH-1:0] tcdm_r_data_i,
    input  logic                  tcdm_r_valid_i
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RD_REQ,
        ST_RD_WAIT,
        ST_RD_OUT,
        ST_WR_DATA,
        ST_WR_REQ
    } state_t;

    state_t                state_q, state_d;
    logic                  src_pend_q, src_pend_d;
    logic                  snk_pend_q, snk_pend_d;
    logic [ADDR_WIDTH-3:0] src_addr_q, src_addr_d;
    logic [ADDR_WIDTH-3:0] snk_addr_q, snk_addr_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic                  src_done_q, src_done_d;
    logic                  snk_done_q, snk_done_d;

    logic                  src_accept;
    logic                  snk_accept;

    // Byte-offset bits of the base addresses are dropped: every access is a full word.
    logic                  unused_addr_bits;
    assign unused_addr_bits = ^{src_base_addr_i[1:0], snk_base_addr_i[1:0]};

    // A strobe only counts while its channel has nothing latched or in service.
    assign src_accept = src_req_start_i && !src_pend_q;
    assign snk_accept = snk_req_start_i && !snk_pend_q;

    // State register and request/data holding registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= ST_IDLE;
            src_pend_q <= 1'b0;
            snk_pend_q <= 1'b0;
            src_addr_q <= '0;
            snk_addr_q <= '0;
            data_q     <= '0;
            src_done_q <= 1'b0;
            snk_done_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            src_pend_q <= src_pend_d;
            snk_pend_q <= snk_pend_d;
            src_addr_q <= src_addr_d;
            snk_addr_q <= snk_addr_d;
            data_q     <= data_d;
            src_done_q <= src_done_d;
            snk_done_q <= snk_done_d;
        end
    end

    // Next-state logic: request latching, transaction sequencing and done pulses.
    always_comb begin
        state_d    = state_q;
        src_pend_d = src_pend_q;
        snk_pend_d = snk_pend_q;
        src_addr_d = src_addr_q;
        snk_addr_d = snk_addr_q;
        data_d     = data_q;
        src_done_d = 1'b0;
        snk_done_d = 1'b0;

        if (clear) begin
            state_d    = ST_IDLE;
            src_pend_d = 1'b0;
            snk_pend_d = 1'b0;
            src_addr_d = '0;
            snk_addr_d = '0;
            data_d     = '0;
        end else begin
            if (src_accept) begin
                src_pend_d = 1'b1;
                src_addr_d = src_base_addr_i[ADDR_WIDTH-1:2];
            end
            if (snk_accept) begin
                snk_pend_d = 1'b1;
                snk_addr_d = snk_base_addr_i[ADDR_WIDTH-1:2];
            end

            unique case (state_q)
                ST_IDLE: begin
                    // A request accepted this cycle starts immediately; source wins ties.
                    if (src_pend_q || src_accept) begin
                        state_d = ST_RD_REQ;
                    end else if (snk_pend_q || snk_accept) begin
                        state_d = ST_WR_DATA;
                    end
                end
                ST_RD_REQ: begin
                    if (tcdm_gnt_i) begin
                        state_d = ST_RD_WAIT;
                    end
                end
                ST_RD_WAIT: begin
                    if (tcdm_r_valid_i) begin
                        data_d  = tcdm_r_data_i;
                        state_d = ST_RD_OUT;
                    end
                end
                ST_RD_OUT: begin
                    if (src_ready_i) begin
                        src_pend_d = 1'b0;
                        src_done_d = 1'b1;
                        state_d    = ST_IDLE;
                    end
                end
                ST_WR_DATA: begin
                    if (snk_valid_i) begin
                        data_d  = snk_data_i;
                        state_d = ST_WR_REQ;
                    end
                end
                ST_WR_REQ: begin
                    if (tcdm_gnt_i) begin
                        snk_pend_d = 1'b0;
                        snk_done_d = 1'b1;
                        state_d    = ST_IDLE;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    // Outputs depend on registered state only, so nothing combinational loops back to the engine.
    always_comb begin
        src_ready_start_o = !src_pend_q;
        snk_ready_start_o = !snk_pend_q;
        src_done_o        = src_done_q;
        snk_done_o        = snk_done_q;
        src_valid_o       = (state_q == ST_RD_OUT);
        src_data_o        = (state_q == ST_RD_OUT) ? data_q : '0;
        snk_ready_o       = (state_q == ST_WR_DATA);
        tcdm_req_o        = (state_q == ST_RD_REQ) || (state_q == ST_WR_REQ);
        tcdm_wen_o        = (state_q != ST_WR_REQ);
        tcdm_be_o         = 4'hF;
        tcdm_data_o       = (state_q == ST_WR_REQ) ? data_q : '0;
        tcdm_add_o        = '0;
        if (state_q == ST_RD_REQ) begin
            tcdm_add_o = {src_addr_q, 2'b00};
        end else if (state_q == ST_WR_REQ) begin
            tcdm_add_o = {snk_addr_q, 2'b00};
        end
    end

endmodule

// File: tb/tb_aes_word_stream_port.sv
// Directed self-checking bench for aes_word_stream_port.

module tb_aes_word_stream_port;

    logic        clk;
    logic        reset_n;
    logic        clear;
    logic        src_req_start_i;
    logic [31:0] src_base_addr_i;
    logic        src_ready_start_o;
    logic        src_done_o;
    logic [31:0] src_data_o;
    logic        src_valid_o;
    logic        src_ready_i;
    logic        snk_req_start_i;
    logic [31:0] snk_base_addr_i;
    logic        snk_ready_start_o;
    logic        snk_done_o;
    logic [31:0] snk_data_i;
    logic        snk_valid_i;
    logic        snk_ready_o;
    logic        tcdm_req_o;
    logic        tcdm_gnt_i;
    logic [31:0] tcdm_add_o;
    logic        tcdm_wen_o;
    logic [3:0]  tcdm_be_o;
    logic [31:0] tcdm_data_o;
    logic [31:0] tcdm_r_data_i;
    logic        tcdm_r_valid_i;

    int tests;
    int failures;

    aes_word_stream_port #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
        .clk               (clk),
        .reset_n           (reset_n),
        .clear             (clear),
        .src_req_start_i   (src_req_start_i),
        .src_base_addr_i   (src_base_addr_i),
        .src_ready_start_o (src_ready_start_o),
        .src_done_o        (src_done_o),
        .src_data_o        (src_data_o),
        .src_valid_o       (src_valid_o),
        .src_ready_i       (src_ready_i),
        .snk_req_start_i   (snk_req_start_i),
        .snk_base_addr_i   (snk_base_addr_i),
        .snk_ready_start_o (snk_ready_start_o),
        .snk_done_o        (snk_done_o),
        .snk_data_i        (snk_data_i),
        .snk_valid_i       (snk_valid_i),
        .snk_ready_o       (snk_ready_o),
        .tcdm_req_o        (tcdm_req_o),
        .tcdm_gnt_i        (tcdm_gnt_i),
        .tcdm_add_o        (tcdm_add_o),
        .tcdm_wen_o        (tcdm_wen_o),
        .tcdm_be_o         (tcdm_be_o),
        .tcdm_data_o       (tcdm_data_o),
        .tcdm_r_data_i     (tcdm_r_data_i),
        .tcdm_r_valid_i    (tcdm_r_valid_i)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one clock; inputs are driven and outputs sampled 1 ns after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        clear           = 1'b0;
        src_req_start_i = 1'b0;
        src_base_addr_i = '0;
        src_ready_i     = 1'b0;
        snk_req_start_i = 1'b0;
        snk_base_addr_i = '0;
        snk_data_i      = '0;
        snk_valid_i     = 1'b0;
        tcdm_gnt_i      = 1'b0;
        tcdm_r_data_i   = '0;
        tcdm_r_valid_i  = 1'b0;
    endtask

    task automatic test_reset();
        logic [12:0] obs;
        idle_inputs();
        reset_n = 1'b0;
        repeat (3) step();
        reset_n = 1'b1;
        step();
        obs = {src_ready_start_o, snk_ready_start_o, tcdm_wen_o, tcdm_be_o,
               tcdm_req_o, src_valid_o, src_done_o, snk_done_o, snk_ready_o, 1'b0};
        tests++;
        if (obs !== 13'b1_1_1_1111_0_0_0_0_0_0) begin
            failures++;
            $display("[TB] FAIL reset_flags got %b expected %b", obs, 13'b1111111000000);
        end
        tests++;
        if (tcdm_add_o !== 32'h0 || tcdm_data_o !== 32'h0 || src_data_o !== 32'h0) begin
            failures++;
            $display("[TB] FAIL reset_buses add=%h data=%h src_data=%h expected all 0",
                     tcdm_add_o, tcdm_data_o, src_data_o);
        end
    endtask

    task automatic test_read_min_latency();
        // cycle 0: strobe
        src_req_start_i = 1'b1;
        src_base_addr_i = 32'h1000_0006;
        step();
        // cycle 1: request on TCDM, granted immediately
        src_req_start_i = 1'b0;
        tests++;
        if (tcdm_req_o !== 1'b1 || tcdm_wen_o !== 1'b1 || tcdm_add_o !== 32'h1000_0004) begin
            failures++;
            $display("[TB] FAIL rd_req req=%b wen=%b add=%h expected 1 1 10000004",
                     tcdm_req_o, tcdm_wen_o, tcdm_add_o);
        end
        tests++;
        if (src_ready_start_o !== 1'b0) begin
            failures++;
            $display("[TB] FAIL rd_ready_start_drop got %b expected 0", src_ready_start_o);
        end
        tcdm_gnt_i = 1'b1;
        step();
        // cycle 2: read data returns
        tcdm_gnt_i     = 1'b0;
        tcdm_r_valid_i = 1'b1;
        tcdm_r_data_i  = 32'hDEAD_BEEF;
        tests++;
        if (tcdm_req_o !== 1'b0 || src_valid_o !== 1'b0) begin
            failures++;
            $display("[TB] FAIL rd_wait req=%b valid=%b expected 0 0", tcdm_req_o, src_valid_o);
        end
        step();
        // cycle 3: word offered to engine
        tcdm_r_valid_i = 1'b0;
        tcdm_r_data_i  = '0;
        tests++;
        if (src_valid_o !== 1'b1 || src_data_o !== 32'hDEAD_BEEF) begin
            failures++;
            $display("[TB] FAIL rd_out valid=%b data=%h expected 1 deadbeef", src_valid_o, src_data_o);
        end
        src_ready_i = 1'b1;
        step();
        // cycle 4: done pulse
        src_ready_i = 1'b0;
        tests++;
        if (src_done_o !== 1'b1 || src_valid_o !== 1'b0 || src_ready_start_o !== 1'b1) begin
            failures++;
            $display("[TB] FAIL rd_done done=%b valid=%b ready_start=%b expected 1 0 1",
                     src_done_o, src_valid_o, src_ready_start_o);
        end
        step();
        tests++;
        if (src_done_o !== 1'b0) begin
            failures++;
            $display("[TB] FAIL rd_done_single got %b expected 0", src_done_o);
        end
    endtask

    task automatic test_read_stall();
        bit stable;
        int done_cnt;
        stable = 1'b1;
        done_cnt = 0;
        src_req_start_i = 1'b1;
        src_base_addr_i = 32'h0000_0403;
        step();
        src_req_start_i = 1'b0;
        for (int i = 0; i < 3; i++) begin
            if (tcdm_req_o !== 1'b1 || tcdm_add_o !== 32'h0000_0400) stable = 1'b0;
            step();
        end
        if (tcdm_req_o !== 1'b1 || tcdm_add_o !== 32'h0000_0400) stable = 1'b0;
        tcdm_gnt_i = 1'b1;
        step();
        tcdm_gnt_i = 1'b0;
        step();
        tcdm_r_valid_i = 1'b1;
        tcdm_r_data_i  = 32'h0BAD_F00D;
        step();
        tcdm_r_valid_i = 1'b0;
        tcdm_r_data_i  = '0;
        for (int i = 0; i < 2; i++) begin
            if (src_valid_o !== 1'b1 || src_data_o !== 32'h0BAD_F00D) stable = 1'b0;
            if (src_done_o) done_cnt++;
            step();
        end
        if (src_valid_o !== 1'b1 || src_data_o !== 32'h0BAD_F00D) stable = 1'b0;
        src_ready_i = 1'b1;
        step();
        src_ready_i = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (src_done_o) done_cnt++;
            step();
        end
        tests++;
        if (stable !== 1'b1) begin
            failures++;
            $display("[TB] FAIL rd_stall_stable got %b expected 1", stable);
        end
        tests++;
        if (done_cnt != 1) begin
            failures++;
            $display("[TB] FAIL rd_stall_done_count got %0d expected 1", done_cnt);
        end
    endtask

    task automatic test_write_delayed();
        bit ready_ok;
        ready_ok = 1'b1;
        snk_req_start_i = 1'b1;
        snk_base_addr_i = 32'h2000_0010;
        step();
        snk_req_start_i = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (snk_ready_o !== 1'b1 || tcdm_req_o !== 1'b0) ready_ok = 1'b0;
            step();
        end
        if (snk_ready_o !== 1'b1) ready_ok = 1'b0;
        snk_valid_i = 1'b1;
        snk_data_i  = 32'hCAFE_F00D;
        step();
        snk_valid_i = 1'b0;
        snk_data_i  = '0;
        tests++;
        if (ready_ok !== 1'b1 || snk_ready_start_o !== 1'b0) begin
            failures++;
            $display("[TB] FAIL wr_data_phase ready_ok=%b ready_start=%b expected 1 0",
                     ready_ok, snk_ready_start_o);
        end
        tests++;
        if (tcdm_req_o !== 1'b1 || tcdm_wen_o !== 1'b0 || tcdm_data_o !== 32'hCAFE_F00D ||
            tcdm_be_o !== 4'hF || tcdm_add_o !== 32'h2000_0010) begin
            failures++;
            $display("[TB] FAIL wr_req req=%b wen=%b data=%h be=%h add=%h expected 1 0 cafef00d f 20000010",
                     tcdm_req_o, tcdm_wen_o, tcdm_data_o, tcdm_be_o, tcdm_add_o);
        end
        tcdm_gnt_i = 1'b1;
        step();
        tcdm_gnt_i = 1'b0;
        tcdm_r_valid_i = 1'b1;
        tests++;
        if (snk_done_o !== 1'b1 || snk_ready_start_o !== 1'b1 || tcdm_req_o !== 1'b0) begin
            failures++;
            $display("[TB] FAIL wr_done done=%b ready_start=%b req=%b expected 1 1 0",
                     snk_done_o, snk_ready_start_o, tcdm_req_o);
        end
        step();
        tcdm_r_valid_i = 1'b0;
        tests++;
        if (snk_done_o !== 1'b0 || src_valid_o !== 1'b0) begin
            failures++;
            $display("[TB] FAIL wr_done_single done=%b src_valid=%b expected 0 0", snk_done_o, src_valid_o);
        end
    endtask

    task automatic test_back_to_back();
        int seq[4];
        int npulses;
        bit both;
        bit rd_prev;
        logic [31:0] rd_seen;
        logic [31:0] wr_seen;
        logic [31:0] wr_add;
        npulses = 0;
        both    = 1'b0;
        rd_prev = 1'b0;
        rd_seen = '0;
        wr_seen = '0;
        wr_add  = '0;
        for (int i = 0; i < 4; i++) seq[i] = 0;
        src_req_start_i = 1'b1;
        src_base_addr_i = 32'h3000_0000;
        snk_req_start_i = 1'b1;
        snk_base_addr_i = 32'h3000_0008;
        snk_data_i      = 32'h55AA_00FF;
        snk_valid_i     = 1'b1;
        src_ready_i     = 1'b1;
        step();
        src_req_start_i = 1'b0;
        snk_req_start_i = 1'b0;
        tests++;
        if (src_ready_start_o !== 1'b0 || snk_ready_start_o !== 1'b0 ||
            tcdm_req_o !== 1'b1 || tcdm_wen_o !== 1'b1) begin
            failures++;
            $display("[TB] FAIL b2b_accept src_rs=%b snk_rs=%b req=%b wen=%b expected 0 0 1 1",
                     src_ready_start_o, snk_ready_start_o, tcdm_req_o, tcdm_wen_o);
        end
        for (int i = 0; i < 20; i++) begin
            tcdm_gnt_i     = tcdm_req_o;
            tcdm_r_valid_i = rd_prev;
            tcdm_r_data_i  = rd_prev ? 32'h1122_3344 : 32'h0;
            rd_prev        = tcdm_req_o && tcdm_wen_o;
            if (src_valid_o) rd_seen = src_data_o;
            if (tcdm_req_o && !tcdm_wen_o) begin
                wr_seen = tcdm_data_o;
                wr_add  = tcdm_add_o;
            end
            step();
            if (src_done_o && snk_done_o) both = 1'b1;
            if (src_done_o && npulses < 4) begin
                seq[npulses] = 1;
                npulses++;
            end
            if (snk_done_o && npulses < 4) begin
                seq[npulses] = 2;
                npulses++;
            end
        end
        idle_inputs();
        tests++;
        if (npulses != 2 || seq[0] != 1 || seq[1] != 2 || both) begin
            failures++;
            $display("[TB] FAIL b2b_order pulses=%0d first=%0d second=%0d both=%b expected 2 1 2 0",
                     npulses, seq[0], seq[1], both);
        end
        tests++;
        if (rd_seen !== 32'h1122_3344 || wr_seen !== 32'h55AA_00FF || wr_add !== 32'h3000_0008) begin
            failures++;
            $display("[TB] FAIL b2b_data rd=%h wr=%h add=%h expected 11223344 55aa00ff 30000008",
                     rd_seen, wr_seen, wr_add);
        end
    endtask

    task automatic test_clear();
        bit spurious;
        spurious = 1'b0;
        src_req_start_i = 1'b1;
        src_base_addr_i = 32'h0000_0100;
        step();
        src_req_start_i = 1'b0;
        tcdm_gnt_i = 1'b1;
        step();
        tcdm_gnt_i = 1'b0;
        clear = 1'b1;
        step();
        clear = 1'b0;
        tcdm_r_valid_i = 1'b1;
        tcdm_r_data_i  = 32'h7777_7777;
        tests++;
        if (src_ready_start_o !== 1'b1 || snk_ready_start_o !== 1'b1 || tcdm_req_o !== 1'b0) begin
            failures++;
            $display("[TB] FAIL clear_ready src_rs=%b snk_rs=%b req=%b expected 1 1 0",
                     src_ready_start_o, snk_ready_start_o, tcdm_req_o);
        end
        src_ready_i = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            tcdm_r_valid_i = 1'b0;
            if (src_valid_o || src_done_o || snk_done_o || tcdm_req_o) spurious = 1'b1;
        end
        idle_inputs();
        tests++;
        if (spurious !== 1'b0) begin
            failures++;
            $display("[TB] FAIL clear_no_activity got %b expected 0", spurious);
        end
    endtask

    task automatic test_async_reset();
        snk_req_start_i = 1'b1;
        snk_base_addr_i = 32'h4000_0000;
        snk_valid_i     = 1'b1;
        snk_data_i      = 32'h1234_5678;
        step();
        snk_req_start_i = 1'b0;
        step();
        snk_valid_i = 1'b0;
        tests++;
        if (tcdm_req_o !== 1'b1 || tcdm_wen_o !== 1'b0) begin
            failures++;
            $display("[TB] FAIL ar_in_wr_req req=%b wen=%b expected 1 0", tcdm_req_o, tcdm_wen_o);
        end
        #2;
        reset_n = 1'b0;
        #1;
        tests++;
        if (tcdm_req_o !== 1'b0 || tcdm_wen_o !== 1'b1 || tcdm_be_o !== 4'hF ||
            tcdm_add_o !== 32'h0 || tcdm_data_o !== 32'h0 || snk_ready_o !== 1'b0 ||
            src_ready_start_o !== 1'b1 || snk_ready_start_o !== 1'b1 || snk_done_o !== 1'b0) begin
            failures++;
            $display("[TB] FAIL ar_outputs req=%b wen=%b be=%h add=%h data=%h snk_rdy=%b rs=%b%b done=%b",
                     tcdm_req_o, tcdm_wen_o, tcdm_be_o, tcdm_add_o, tcdm_data_o, snk_ready_o,
                     src_ready_start_o, snk_ready_start_o, snk_done_o);
        end
        step();
        reset_n = 1'b1;
        src_req_start_i = 1'b1;
        src_base_addr_i = 32'h5000_0005;
        step();
        src_req_start_i = 1'b0;
        tests++;
        if (tcdm_req_o !== 1'b1 || tcdm_wen_o !== 1'b1 || tcdm_add_o !== 32'h5000_0004) begin
            failures++;
            $display("[TB] FAIL ar_new_read req=%b wen=%b add=%h expected 1 1 50000004",
                     tcdm_req_o, tcdm_wen_o, tcdm_add_o);
        end
        tcdm_gnt_i = 1'b1;
        step();
        tcdm_gnt_i     = 1'b0;
        tcdm_r_valid_i = 1'b1;
        tcdm_r_data_i  = 32'hA5A5_5A5A;
        step();
        tcdm_r_valid_i = 1'b0;
        tcdm_r_data_i  = '0;
        src_ready_i    = 1'b1;
        tests++;
        if (src_valid_o !== 1'b1 || src_data_o !== 32'hA5A5_5A5A) begin
            failures++;
            $display("[TB] FAIL ar_read_data valid=%b data=%h expected 1 a5a55a5a", src_valid_o, src_data_o);
        end
        step();
        src_ready_i = 1'b0;
        tests++;
        if (src_done_o !== 1'b1 || snk_done_o !== 1'b0) begin
            failures++;
            $display("[TB] FAIL ar_read_done src=%b snk=%b expected 1 0", src_done_o, snk_done_o);
        end
        step();
    endtask

    initial begin
        tests    = 0;
        failures = 0;
        reset_n  = 1'b0;
        idle_inputs();
        test_reset();
        test_read_min_latency();
        test_read_stall();
        test_write_delayed();
        test_back_to_back();
        test_clear();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", tests, failures);
        $finish;
    end

endmodule

// File: doc/aes_word_stream_port.md
# aes_word_stream_port

Responder side of the per-word streamer handshake driven by the AES control FSM. Accepts single-word read (source) and write (sink) requests, each carrying a base address, and executes them on one shared 32-bit TCDM master port. Delivers read words to the engine on a valid/ready stream, takes write words from the engine on a valid/ready stream, and reports `ready_start`/`done` back to the controller.

## Interface
- `ADDR_WIDTH`, 32, TCDM byte address width
- `DATA_WIDTH`, 32, word width; fixed at 32, other values unsupported
- `clk` in 1 clock
- `reset_n` in 1 reset, asynchronous, active-low
- `clear` in 1 synchronous soft clear
- `src_req_start_i` in 1 read request strobe
- `src_base_addr_i` in ADDR_WIDTH read byte address; sampled with `src_req_start_i`
- `src_ready_start_o` out 1 source channel can accept a request
- `src_done_o` out 1 one-cycle pulse: read word handed to engine
- `src_data_o` out 32 read word to engine
- `src_valid_o` out 1 read word valid
- `src_ready_i` in 1 engine accepts read word
- `snk_req_start_i` in 1 write request strobe
- `snk_base_addr_i` in ADDR_WIDTH write byte address; sampled with `snk_req_start_i`
- `snk_ready_start_o` out 1 sink channel can accept a request
- `snk_done_o` out 1 one-cycle pulse: write granted by TCDM
- `snk_data_i` in 32 write word from engine
- `snk_valid_i` in 1 write word valid
- `snk_ready_o` out 1 port accepts write word
- `tcdm_req_o` out 1 TCDM request
- `tcdm_gnt_i` in 1 TCDM grant
- `tcdm_add_o` out ADDR_WIDTH word-aligned address
- `tcdm_wen_o` out 1 1 = read, 0 = write
- `tcdm_be_o` out 4 byte enables, always 4'hF
- `tcdm_data_o` out 32 write data
- `tcdm_r_data_i` in 32 read data
- `tcdm_r_valid_i` in 1 read data valid

## Operation
- States: IDLE, RD_REQ, RD_WAIT, RD_OUT, WR_DATA, WR_REQ.
- Request acceptance: `src_ready_start_o` = no source request latched or in service; `snk_ready_start_o` likewise for sink. A strobe with its ready high latches the address; strobes with ready low are ignored.
- Both channels may be accepted in the same cycle; one transaction in flight at a time; source has priority when both pending in IDLE.
- Address: `tcdm_add_o = {base[ADDR_WIDTH-1:2], 2'b00}`; low two bits ignored.
- IDLE -> RD_REQ if source pending, else -> WR_DATA if sink pending.
- RD_REQ: `tcdm_req_o`=1, `tcdm_wen_o`=1, held until `tcdm_gnt_i`; then -> RD_WAIT.
- RD_WAIT: on `tcdm_r_valid_i` capture `tcdm_r_data_i` into data register -> RD_OUT; any latency >=1 cycle accepted.
- RD_OUT: `src_valid_o`=1, `src_data_o` = captured word stable; on `src_ready_i` -> IDLE, source pending cleared, `src_done_o` pulses next cycle.
- WR_DATA: `snk_ready_o`=1; on `snk_valid_i` capture `snk_data_i` -> WR_REQ.
- WR_REQ: `tcdm_req_o`=1, `tcdm_wen_o`=0, `tcdm_data_o` = captured word, held until `tcdm_gnt_i`; then -> IDLE, sink pending cleared, `snk_done_o` pulses next cycle. `tcdm_r_valid_i` after a write grant ignored.
- `tcdm_r_valid_i` outside RD_WAIT ignored.

## Timing
- Reset / clear: state IDLE, pending flags 0, data register 0; all outputs 0 except `src_ready_start_o`=1, `snk_ready_start_o`=1, `tcdm_wen_o`=1, `tcdm_be_o`=4'hF.
- `clear` has priority over all events in the same cycle; drops pending requests and in-flight transaction; a later `r_valid` for a dropped read is ignored; no `done` pulses.
- `ready_start` outputs fall the cycle after acceptance, rise the cycle after the matching `done` pulse's triggering event.
- Read minimum latency (gnt same cycle, r_valid +1, src_ready high): strobe cycle 0, `tcdm_req_o` cycle 1, capture cycle 2, `src_valid_o` cycle 3, `src_done_o` cycle 4.
- Write minimum latency (snk_valid high, gnt same cycle): strobe cycle 0, `snk_ready_o` cycle 1, `tcdm_req_o` cycle 2, `snk_done_o` cycle 3.
- `done` pulses exactly one cycle per accepted request; never both in the same cycle.

## Test plan
- Read 0x1000_0006, memory[0x1000_0004]=0xDEADBEEF, gnt immediate, r_valid +1 -> `tcdm_add_o`=0x1000_0004, `src_data_o`=0xDEADBEEF at cycle 3, `src_done_o` single pulse cycle 4.
- Read with gnt stalled 3 cycles and `src_ready_i` low 2 cycles -> `tcdm_req_o`, address and `src_data_o` held stable; one `src_done_o` pulse.
- Write 0xCAFEF00D to 0x2000_0010, `snk_valid_i` delayed 4 cycles -> `tcdm_wen_o`=0, `tcdm_data_o`=0xCAFEF00D, `tcdm_be_o`=4'hF; `snk_done_o` one cycle after gnt.
- Simultaneous src and snk strobes -> both ready_start drop; read completes first, then write; two done pulses in order src, snk.
- `clear` in RD_WAIT, late r_valid arrives -> no `src_valid_o`, no `src_done_o`, both ready_start=1.
- Async reset mid-WR_REQ -> all outputs at reset values immediately; new read after release completes normally.
